io_display_scan: RTL and testbench

- Downstream consumer of the MEM stage's memory-mapped output ports out_port0..2.
- Converts the three 32-bit port values to decimal: out_port0 and out_port1 as 2 digits each, out_port2 as 4 digits.
- Drives an 8-digit multiplexed seven-segment display with one shared segment bus and a one-hot digit enable.
- Conversion uses a sequential double-dabble engine that round-robins over the three ports.

---
 rtl/io_display_scan_pkg.sv | 52 +++++
 rtl/io_display_scan_if.sv | 20 ++
 rtl/io_display_scan_bin2bcd.sv | 61 ++++++
 rtl/io_display_scan.sv | 110 +++++++++++
 tb/tb_io_display_scan.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/io_display_scan_pkg.sv
// Shared types and constants for the decimal display scanner: converter states,
// seven-segment glyphs, saturation limits and small decode helpers.
package io_disp_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_t;

  localparam int BIN_W       = 14;
  localparam int SHIFT_STEPS = 14;
  localparam int BCD_W       = 16;

  localparam logic [31:0] SAT_LIM_2DIG = 32'd99;
  localparam logic [31:0] SAT_LIM_4DIG = 32'd9999;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [BIN_W-1:0] sat_value(input logic [31:0] v, input logic [31:0] lim);
    return BIN_W'((v > lim) ? lim : v);
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d, input logic blank);
    if (blank) return SEG_BLANK;
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/io_display_scan_if.sv
// MEM-stage output ports toward the display scanner, plus the display drive
// and committed BCD coming back.
interface io_display_scan_if;
  logic [31:0] out_port0;
  logic [31:0] out_port1;
  logic [31:0] out_port2;
  logic [6:0]  seg_n;
  logic [7:0]  dig_en;
  logic [31:0] disp_bcd;

  modport master (
    output out_port0, out_port1, out_port2,
    input  seg_n, dig_en, disp_bcd
  );

  modport slave (
    input  out_port0, out_port1, out_port2,
    output seg_n, dig_en, disp_bcd
  );
endinterface

// File: rtl/io_display_scan_bin2bcd.sv
// Sequential double-dabble: 14-bit binary to 4-digit BCD in 16 cycles.
//   state     | meaning
//   ST_LOAD   | snapshot value, clear accumulator (waits here while start is low)
//   ST_SHIFT  | 14 add-3/shift steps
//   ST_COMMIT | bcd valid, done high for this one cycle
module io_bin2bcd_seq
  import io_disp_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [BIN_W-1:0] value,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);

  conv_state_t      state;
  logic [BIN_W-1:0] bin;
  logic [3:0]       step;
  logic [BCD_W-1:0] acc_adj;

  always_comb begin
    acc_adj = bcd;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_LOAD;
      bin   <= '0;
      bcd   <= '0;
      step  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (start) begin
            bin   <= value;
            bcd   <= '0;
            step  <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {bcd, bin} <= {acc_adj, bin} << 1;
          step       <= step + 4'd1;
          if (step == 4'(SHIFT_STEPS - 1)) begin
            state <= ST_COMMIT;
            done  <= 1'b1;
          end
        end
        ST_COMMIT: state <= ST_LOAD;
        default:   state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: rtl/io_display_scan.sv
// Round-robin decimal conversion of three output ports and 8-digit multiplexed
// seven-segment scanning with leading-zero blanking.
module io_display_scan
  import io_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000
)
(
  input  logic          clk,
  input  logic          clr,
  io_display_scan_if.slave bus
);

  localparam int PW = $clog2(SCAN_DIV);

  logic [BIN_W-1:0] v0, v1, v2, conv_value;
  logic [1:0]       sel;
  logic [BCD_W-1:0] conv_bcd;
  logic             conv_done;
  logic [31:0]      disp_q;

  assign v0 = sat_value(bus.out_port0, SAT_LIM_2DIG);
  assign v1 = sat_value(bus.out_port1, SAT_LIM_2DIG);
  assign v2 = sat_value(bus.out_port2, SAT_LIM_4DIG);

  always_comb begin
    case (sel)
      2'd0:    conv_value = v0;
      2'd1:    conv_value = v1;
      default: conv_value = v2;
    endcase
  end

  io_bin2bcd_seq u_conv (
    .clk   (clk),
    .clr   (clr),
    .start (1'b1),
    .value (conv_value),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      sel    <= 2'd0;
      disp_q <= '0;
    end else if (conv_done) begin
      case (sel)
        2'd0: begin
          disp_q[31:24] <= conv_bcd[7:0];
          sel           <= 2'd1;
        end
        2'd1: begin
          disp_q[23:16] <= conv_bcd[7:0];
          sel           <= 2'd2;
        end
        default: begin
          disp_q[15:0] <= conv_bcd;
          sel          <= 2'd0;
        end
      endcase
    end
  end

  logic [PW-1:0] pre;
  logic          tick;
  logic [2:0]    idx, idx_next;
  logic [3:0]    nib;
  logic          blank;
  logic [6:0]    seg_q;
  logic [7:0]    dig_q;

  assign tick     = (pre == PW'(SCAN_DIV - 1));
  assign idx_next = idx + 3'd1;
  assign nib      = disp_q[{idx_next, 2'b00} +: 4];

  // Leading zeros of the 4-digit field blank from the left; the 2-digit fields only blank their tens.
  always_comb begin
    blank = 1'b0;
    case (idx_next)
      3'd7:    blank = (disp_q[31:28] == 4'd0);
      3'd5:    blank = (disp_q[23:20] == 4'd0);
      3'd3:    blank = (disp_q[15:12] == 4'd0);
      3'd2:    blank = (disp_q[15:8] == 8'd0);
      3'd1:    blank = (disp_q[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pre   <= '0;
      idx   <= 3'd0;
      dig_q <= 8'h01;
      seg_q <= SEG_BLANK;
    end else if (tick) begin
      pre   <= '0;
      idx   <= idx_next;
      dig_q <= 8'b1 << idx_next;
      seg_q <= seg_decode(nib, blank);
    end else begin
      pre <= pre + PW'(1);
    end
  end

  assign bus.seg_n    = seg_q;
  assign bus.dig_en   = dig_q;
  assign bus.disp_bcd = disp_q;

endmodule

// File: tb/tb_io_display_scan.sv
// Self-checking bench for io_display_scan: vector table, exact-timing sequences
// and randomized ports against a decimal-arithmetic reference model.
module tb_io_display_scan;

  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  io_display_scan_if bus();

  io_display_scan #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] p0;
    logic [31:0] p1;
    logic [31:0] p2;
    logic [31:0] exp_bcd;
  } vec_t;

  vec_t       vecs[7];
  logic [6:0] glyph_lut[10];

  function automatic int unsigned satv(logic [31:0] v, int unsigned lim);
    return (v > lim) ? lim : int'(v);
  endfunction

  function automatic logic [31:0] model_bcd(logic [31:0] p0, logic [31:0] p1, logic [31:0] p2);
    int unsigned a, b, c;
    logic [31:0] r;
    a = satv(p0, 99);
    b = satv(p1, 99);
    c = satv(p2, 9999);
    r[31:28] = 4'(a / 10);
    r[27:24] = 4'(a % 10);
    r[23:20] = 4'(b / 10);
    r[19:16] = 4'(b % 10);
    r[15:12] = 4'(c / 1000);
    r[11:8]  = 4'((c / 100) % 10);
    r[7:4]   = 4'((c / 10) % 10);
    r[3:0]   = 4'(c % 10);
    return r;
  endfunction

  function automatic logic [6:0] model_glyph(int k, logic [31:0] p0, logic [31:0] p1, logic [31:0] p2);
    int unsigned a, b, c, d;
    bit blank;
    a = satv(p0, 99);
    b = satv(p1, 99);
    c = satv(p2, 9999);
    blank = 1'b0;
    case (k)
      7: begin d = a / 10; blank = (a < 10); end
      6: d = a % 10;
      5: begin d = b / 10; blank = (b < 10); end
      4: d = b % 10;
      3: begin d = c / 1000; blank = (c < 1000); end
      2: begin d = (c / 100) % 10; blank = (c < 100); end
      1: begin d = (c / 10) % 10; blank = (c < 10); end
      default: d = c % 10;
    endcase
    return blank ? 7'h7F : glyph_lut[d];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick_neg();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ports(logic [31:0] a, logic [31:0] b, logic [31:0] c);
    bus.out_port0 = a;
    bus.out_port1 = b;
    bus.out_port2 = c;
  endtask

  // Returns at the negedge right after the last clr-sampling posedge.
  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic wait_bcd(logic [31:0] exp);
    bit ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      tick_neg();
      if (bus.disp_bcd === exp) ok = 1'b1;
    end
    check("latency64", bus.disp_bcd, exp);
  endtask

  task automatic scan_check(logic [31:0] p0, logic [31:0] p1, logic [31:0] p2);
    int k;
    repeat (SCAN_DIV) tick_neg();
    for (int c = 0; c < 8 * SCAN_DIV; c++) begin
      tick_neg();
      check("onehot", 32'($onehot(bus.dig_en)), 32'd1);
      k = 0;
      for (int b = 0; b < 8; b++) if (bus.dig_en[b]) k = b;
      check($sformatf("seg_dig%0d", k), 32'(bus.seg_n), 32'(model_glyph(k, p0, p1, p2)));
    end
  endtask

  function automatic logic [31:0] rand_port(int unsigned lim);
    case ($urandom_range(0, 4))
      0:       return 32'($urandom_range(0, 9));
      1:       return 32'($urandom_range(0, lim));
      2:       return 32'(lim);
      3:       return 32'(lim + 1);
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp;
    logic [31:0] a, b, c;

    glyph_lut = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    vecs[0] = '{32'd0,          32'd0,  32'd0,     32'h0000_0000};
    vecs[1] = '{32'd42,         32'd7,  32'd1234,  32'h4207_1234};
    vecs[2] = '{32'hFFFF_FFFF,  32'd7,  32'd10000, 32'h9907_9999};
    vecs[3] = '{32'd0,          32'd0,  32'd5,     32'h0000_0005};
    vecs[4] = '{32'd100,        32'd99, 32'd9999,  32'h9999_9999};
    vecs[5] = '{32'd10,         32'd55, 32'd1000,  32'h1055_1000};
    vecs[6] = '{32'd9,          32'd3,  32'd99,    32'h0903_0099};

    clr = 1'b0;
    set_ports(0, 0, 0);

    // Reset state and exact tick cadence with all-zero ports
    do_clr();
    for (int cyc = 0; cyc < 9 * SCAN_DIV; cyc++) begin
      if (cyc > 0) tick_neg();
      check("rst_dig_en", 32'(bus.dig_en), 32'(8'b1 << ((cyc / SCAN_DIV) % 8)));
      check("rst_seg_n", 32'(bus.seg_n),
            (cyc < SCAN_DIV) ? 32'h7F : 32'(model_glyph((cyc / SCAN_DIV) % 8, 0, 0, 0)));
    end
    check("rst_disp", bus.disp_bcd, 32'd0);

    for (int i = 0; i < 7; i++) begin
      set_ports(vecs[i].p0, vecs[i].p1, vecs[i].p2);
      wait_bcd(vecs[i].exp_bcd);
      scan_check(vecs[i].p0, vecs[i].p1, vecs[i].p2);
    end

    // port2 changes one cycle after its snapshot: old value commits first
    set_ports(0, 0, 1234);
    do_clr();
    for (int cyc = 1; cyc <= 100; cyc++) begin
      tick_neg();
      exp = (cyc < 48) ? 32'h0 : (cyc < 96) ? 32'h1234 : 32'h5678;
      check("snap_seq", bus.disp_bcd, exp);
      if (cyc == 33) bus.out_port2 = 32'd5678;
    end

    // clr during port1 conversion: no commit, restart at port0
    set_ports(42, 88, 1234);
    do_clr();
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick_neg();
      if (cyc == 16) check("pre_clr_disp", bus.disp_bcd, 32'h4200_0000);
    end
    clr = 1'b1;
    tick_neg();
    clr = 1'b0;
    check("midclr_disp", bus.disp_bcd, 32'h0);
    check("midclr_dig_en", 32'(bus.dig_en), 32'h01);
    check("midclr_seg_n", 32'(bus.seg_n), 32'h7F);
    for (int cyc = 1; cyc <= 32; cyc++) begin
      tick_neg();
      exp = (cyc < 16) ? 32'h0 : (cyc < 32) ? 32'h4200_0000 : 32'h4288_0000;
      check("restart_seq", bus.disp_bcd, exp);
    end

    for (int r = 0; r < 20; r++) begin
      a = rand_port(99);
      b = rand_port(99);
      c = rand_port(9999);
      set_ports(a, b, c);
      wait_bcd(model_bcd(a, b, c));
      scan_check(a, b, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
